// File: rtl/trigger_pulse_generator.sv
// Pulse output stage: turns a single-cycle trigger into one pulse with
// programmable delay, width and polarity, configured over the serial register bus.
module trigger_pulse_generator #(
  parameter int         DELAY_BITS      = 24,
  parameter int         WIDTH_BITS      = 16,
  parameter int         COUNT_BITS      = 16,
  parameter logic [7:0] PULSE_GEN_CFG   = 8'h70,
  parameter logic [7:0] PULSE_GEN_DELAY = 8'h71,
  parameter logic [7:0] PULSE_GEN_WIDTH = 8'h72,
  parameter logic [7:0] PULSE_GEN_COUNT = 8'h73
) (
  input  logic        clk_usb,
  input  logic        reset,
  input  logic [7:0]  reg_cmd,
  input  logic [15:0] reg_bytecount,
  input  logic [7:0]  reg_data_in,
  output logic [7:0]  reg_data_out,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        trigger_in,
  output logic        pulse_out,
  output logic        busy
);

  localparam int DELAY_BYTES = DELAY_BITS / 8;
  localparam int WIDTH_BYTES = WIDTH_BITS / 8;
  localparam int COUNT_BYTES = COUNT_BITS / 8;

  localparam logic [DELAY_BITS-1:0] DELAY_ONE = DELAY_BITS'(1);
  localparam logic [WIDTH_BITS-1:0] WIDTH_ONE = WIDTH_BITS'(1);
  localparam logic [COUNT_BITS-1:0] COUNT_ONE = COUNT_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_PULSE
  } state_t;

  state_t                 state_q, state_d;
  logic                   trigPrev_q;
  logic [2:0]             cfg_q, cfg_d;
  logic                   armed_q, armed_d;
  logic [DELAY_BITS-1:0]  delay_q, delay_d;
  logic [WIDTH_BITS-1:0]  width_q, width_d;
  logic [COUNT_BITS-1:0]  count_q, count_d;
  logic [DELAY_BITS-1:0]  delayCnt_q, delayCnt_d;
  logic [WIDTH_BITS-1:0]  widthCnt_q, widthCnt_d;
  logic                   pulseOut_q;
  logic                   busy_q;

  logic                   armStrobe;
  logic                   disarm;
  logic                   triggerEvent;
  logic [WIDTH_BITS-1:0]  widthLoad;

  assign triggerEvent = trigger_in & ~trigPrev_q;
  assign widthLoad    = (width_q == '0) ? WIDTH_ONE : width_q;

  always_comb begin
    cfg_d     = cfg_q;
    delay_d   = delay_q;
    width_d   = width_q;
    armStrobe = 1'b0;
    if (reg_write) begin
      case (reg_cmd)
        PULSE_GEN_CFG: begin
          if (reg_bytecount == 16'd0) begin
            cfg_d     = reg_data_in[2:0];
            armStrobe = reg_data_in[3];
          end
        end
        PULSE_GEN_DELAY: begin
          for (int i = 0; i < DELAY_BYTES; i++)
            if (reg_bytecount == 16'(i)) delay_d[8*i +: 8] = reg_data_in;
        end
        PULSE_GEN_WIDTH: begin
          for (int i = 0; i < WIDTH_BYTES; i++)
            if (reg_bytecount == 16'(i)) width_d[8*i +: 8] = reg_data_in;
        end
        default: ;
      endcase
    end
  end

  // EN is taken from the post-write value so clearing it aborts in the same cycle.
  always_comb begin
    state_d    = state_q;
    delayCnt_d = delayCnt_q;
    widthCnt_d = widthCnt_q;
    count_d    = count_q;
    disarm     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (triggerEvent && cfg_q[0] && armed_q) begin
          delayCnt_d = delay_q;
          widthCnt_d = widthLoad;
          state_d    = (delay_q != '0) ? ST_DELAY : ST_PULSE;
        end
      end
      ST_DELAY: begin
        if (!cfg_d[0]) begin
          state_d = ST_IDLE;
        end else begin
          delayCnt_d = delayCnt_q - DELAY_ONE;
          if (delayCnt_q == DELAY_ONE) state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (!cfg_d[0]) begin
          state_d = ST_IDLE;
        end else begin
          widthCnt_d = widthCnt_q - WIDTH_ONE;
          if (widthCnt_q == WIDTH_ONE) begin
            state_d = ST_IDLE;
            count_d = count_q + COUNT_ONE;
            disarm  = cfg_q[2];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A rearm strobe landing on the one-shot disarm cycle leaves the block armed.
  always_comb begin
    armed_d = armed_q;
    if (disarm)    armed_d = 1'b0;
    if (armStrobe) armed_d = 1'b1;
  end

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      trigPrev_q <= 1'b0;
      cfg_q      <= '0;
      armed_q    <= 1'b1;
      delay_q    <= '0;
      width_q    <= WIDTH_ONE;
      count_q    <= '0;
      delayCnt_q <= '0;
      widthCnt_q <= '0;
      pulseOut_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trigPrev_q <= trigger_in;
      cfg_q      <= cfg_d;
      armed_q    <= armed_d;
      delay_q    <= delay_d;
      width_q    <= width_d;
      count_q    <= count_d;
      delayCnt_q <= delayCnt_d;
      widthCnt_q <= widthCnt_d;
      pulseOut_q <= (state_d == ST_PULSE) ^ cfg_d[1];
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    reg_data_out = 8'h00;
    if (reg_read) begin
      case (reg_cmd)
        PULSE_GEN_CFG: begin
          if (reg_bytecount == 16'd0)
            reg_data_out = {busy_q, armed_q, 3'b000, cfg_q};
        end
        PULSE_GEN_DELAY: begin
          for (int i = 0; i < DELAY_BYTES; i++)
            if (reg_bytecount == 16'(i)) reg_data_out = delay_q[8*i +: 8];
        end
        PULSE_GEN_WIDTH: begin
          for (int i = 0; i < WIDTH_BYTES; i++)
            if (reg_bytecount == 16'(i)) reg_data_out = width_q[8*i +: 8];
        end
        PULSE_GEN_COUNT: begin
          for (int i = 0; i < COUNT_BYTES; i++)
            if (reg_bytecount == 16'(i)) reg_data_out = count_q[8*i +: 8];
        end
        default: ;
      endcase
    end
  end

  assign pulse_out = pulseOut_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_trigger_pulse_generator.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor
// pops and compares them against pulse_out, busy and reg_data_out.
module tb_trigger_pulse_generator;

  localparam logic [7:0] CMD_CFG   = 8'h70;
  localparam logic [7:0] CMD_DELAY = 8'h71;
  localparam logic [7:0] CMD_WIDTH = 8'h72;
  localparam logic [7:0] CMD_COUNT = 8'h73;

  localparam int K_PO   = 0;
  localparam int K_BUSY = 1;
  localparam int K_RD   = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] exp;
  } sbEntry_t;

  logic        clk_usb;
  logic        reset;
  logic [7:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic [7:0]  reg_data_in;
  logic [7:0]  reg_data_out;
  logic        reg_read;
  logic        reg_write;
  logic        trigger_in;
  logic        pulse_out;
  logic        busy;

  sbEntry_t sbQ[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int t;

  trigger_pulse_generator #(
    .DELAY_BITS(24), .WIDTH_BITS(16), .COUNT_BITS(16),
    .PULSE_GEN_CFG(CMD_CFG), .PULSE_GEN_DELAY(CMD_DELAY),
    .PULSE_GEN_WIDTH(CMD_WIDTH), .PULSE_GEN_COUNT(CMD_COUNT)
  ) dut (
    .clk_usb(clk_usb),
    .reset(reset),
    .reg_cmd(reg_cmd),
    .reg_bytecount(reg_bytecount),
    .reg_data_in(reg_data_in),
    .reg_data_out(reg_data_out),
    .reg_read(reg_read),
    .reg_write(reg_write),
    .trigger_in(trigger_in),
    .pulse_out(pulse_out),
    .busy(busy)
  );

  initial clk_usb = 1'b0;
  always #5 clk_usb = ~clk_usb;

  always @(posedge clk_usb) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int c, input logic [7:0] act,
                             input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%02h, expected 0x%02h", name, c, act, exp);
    end
  endtask

  // Monitor: every expectation due this cycle is compared and retired.
  always @(negedge clk_usb) begin
    for (int i = sbQ.size() - 1; i >= 0; i--) begin
      if (sbQ[i].cyc == cyc) begin
        case (sbQ[i].kind)
          K_PO:    checkOutput("pulse_out", cyc, {7'd0, pulse_out}, sbQ[i].exp);
          K_BUSY:  checkOutput("busy", cyc, {7'd0, busy}, sbQ[i].exp);
          default: checkOutput("reg_data_out", cyc, reg_data_out, sbQ[i].exp);
        endcase
        sbQ.delete(i);
      end
    end
  end

  task automatic expectAt(input int c, input int k, input logic [7:0] v);
    sbQ.push_back('{cyc: c, kind: k, exp: v});
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] cmd,
                               input logic [15:0] bc, input logic [7:0] data,
                               input logic trig);
    reg_write     = wr;
    reg_read      = rd;
    reg_cmd       = cmd;
    reg_bytecount = bc;
    reg_data_in   = data;
    trigger_in    = trig;
    @(posedge clk_usb);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0);
  endtask

  task automatic trig();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b1);
  endtask

  task automatic regWrite(input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] data);
    applyStimulus(1'b1, 1'b0, cmd, bc, data, 1'b0);
  endtask

  task automatic regRead(input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] exp);
    expectAt(cyc, K_RD, exp);
    applyStimulus(1'b0, 1'b1, cmd, bc, 8'h00, 1'b0);
  endtask

  // Trigger event in cycle tt: busy over tt+1..tt+d+w, active pulse over tt+1+d..tt+d+w.
  task automatic expectPulse(input int tt, input int d, input int w, input logic pol,
                             input int span);
    logic act, bsy;
    for (int c = tt; c <= tt + span; c++) begin
      act = (c >= tt + 1 + d) && (c <= tt + d + w);
      bsy = (c >= tt + 1) && (c <= tt + d + w);
      expectAt(c, K_PO, {7'd0, act ^ pol});
      expectAt(c, K_BUSY, {7'd0, bsy});
    end
  endtask

  task automatic expectQuiet(input int tt, input int span);
    for (int c = tt; c <= tt + span; c++) begin
      expectAt(c, K_PO, 8'h00);
      expectAt(c, K_BUSY, 8'h00);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    idle(3);
    reset = 1'b0;

    // Reset state
    expectQuiet(cyc, 0);
    regRead(CMD_CFG, 0, 8'h40);
    regRead(CMD_DELAY, 0, 8'h00);
    regRead(CMD_WIDTH, 0, 8'h01);
    regRead(CMD_WIDTH, 1, 8'h00);
    regRead(CMD_COUNT, 0, 8'h00);
    regRead(8'h00, 0, 8'h00);
    expectAt(cyc, K_RD, 8'h00);
    applyStimulus(1'b0, 1'b0, CMD_CFG, 16'h0000, 8'h00, 1'b0);

    // EN, DELAY=0, WIDTH=1: single pulse one cycle after the trigger
    regWrite(CMD_CFG, 0, 8'h01);
    t = cyc;
    expectPulse(t, 0, 1, 1'b0, 3);
    trig();
    idle(4);
    regRead(CMD_COUNT, 0, 8'h01);
    regRead(CMD_COUNT, 1, 8'h00);

    // DELAY=5, WIDTH=3; retrigger at t+4 ignored
    regWrite(CMD_DELAY, 0, 8'd5);
    regWrite(CMD_DELAY, 1, 8'd0);
    regWrite(CMD_DELAY, 2, 8'd0);
    regWrite(CMD_WIDTH, 0, 8'd3);
    regWrite(CMD_WIDTH, 1, 8'd0);
    t = cyc;
    expectPulse(t, 5, 3, 1'b0, 10);
    trig();
    idle(3);
    trig();
    idle(7);
    regRead(CMD_COUNT, 0, 8'h02);

    // One-shot: second trigger ignored until rearmed
    regWrite(CMD_CFG, 0, 8'h05);
    regWrite(CMD_DELAY, 0, 8'd0);
    regWrite(CMD_WIDTH, 0, 8'd2);
    t = cyc;
    expectPulse(t, 0, 2, 1'b0, 4);
    trig();
    idle(4);
    regRead(CMD_CFG, 0, 8'h05);
    idle(4);
    expectQuiet(cyc, 4);
    trig();
    idle(4);
    regRead(CMD_CFG, 0, 8'h05);
    regWrite(CMD_CFG, 0, 8'h0D);
    regRead(CMD_CFG, 0, 8'h45);
    t = cyc;
    expectPulse(t, 0, 2, 1'b0, 4);
    trig();
    idle(4);
    regRead(CMD_CFG, 0, 8'h05);
    regRead(CMD_COUNT, 0, 8'h04);

    // POL=1, WIDTH=4, trigger held high for 20 cycles
    regWrite(CMD_CFG, 0, 8'h0B);
    regWrite(CMD_WIDTH, 0, 8'd4);
    t = cyc;
    expectPulse(t, 0, 4, 1'b1, 22);
    repeat (20) trig();
    idle(4);
    regRead(CMD_COUNT, 0, 8'h05);
    regRead(CMD_CFG, 0, 8'h43);

    // DELAY byte access, out-of-range write, then abort by clearing EN
    regWrite(CMD_CFG, 0, 8'h01);
    regWrite(CMD_DELAY, 0, 8'h03);
    regWrite(CMD_DELAY, 1, 8'h02);
    regWrite(CMD_DELAY, 2, 8'h01);
    regWrite(CMD_DELAY, 3, 8'hFF);
    regRead(CMD_DELAY, 0, 8'h03);
    regRead(CMD_DELAY, 1, 8'h02);
    regRead(CMD_DELAY, 2, 8'h01);
    regRead(CMD_DELAY, 3, 8'h00);
    regWrite(CMD_DELAY, 0, 8'd100);
    regWrite(CMD_DELAY, 1, 8'd0);
    regWrite(CMD_DELAY, 2, 8'd0);
    t = cyc;
    for (int c = t; c <= t + 60; c++) begin
      expectAt(c, K_PO, 8'h00);
      expectAt(c, K_BUSY, {7'd0, (c >= t + 1) && (c <= t + 50)});
    end
    trig();
    idle(49);
    regWrite(CMD_CFG, 0, 8'h00);
    idle(10);
    regRead(CMD_COUNT, 0, 8'h05);
    regRead(CMD_CFG, 0, 8'h40);

    // WIDTH=0 behaves as a one-cycle pulse
    regWrite(CMD_CFG, 0, 8'h01);
    regWrite(CMD_DELAY, 0, 8'd0);
    regWrite(CMD_WIDTH, 0, 8'd0);
    regWrite(CMD_WIDTH, 1, 8'd0);
    t = cyc;
    expectPulse(t, 0, 1, 1'b0, 3);
    trig();
    idle(3);
    regRead(CMD_COUNT, 0, 8'h06);

    // Reset in the 4th cycle of a 10-cycle pulse
    regWrite(CMD_WIDTH, 0, 8'd10);
    t = cyc;
    for (int c = t; c <= t + 9; c++) begin
      expectAt(c, K_PO, {7'd0, (c >= t + 1) && (c <= t + 4)});
      expectAt(c, K_BUSY, {7'd0, (c >= t + 1) && (c <= t + 4)});
    end
    trig();
    idle(3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    regRead(CMD_CFG, 0, 8'h40);
    regRead(CMD_DELAY, 0, 8'h00);
    regRead(CMD_WIDTH, 0, 8'h01);
    regRead(CMD_WIDTH, 1, 8'h00);
    regRead(CMD_COUNT, 0, 8'h00);
    idle(3);

    foreach (sbQ[i]) begin
      checks++;
      errors++;
      $display("[TB] FAIL unchecked_kind%0d due cycle %0d: got no comparison, expected 0x%02h",
               sbQ[i].kind, sbQ[i].cyc, sbQ[i].exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
